// File: rtl/lif_sched.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one neuron update per SWEEP cycle.
// Optional per-neuron refractory counters are enabled by defining LIF_SCHED_REFRACTORY_EN.
module lif_sched #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tick,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  input  logic [W-1:0]                 cur_in,
  input  logic [W-1:0]                 threshold,
  input  logic [2:0]                   leak_shift,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spikes,
  output logic [W-1:0]                 v_mon,
  output logic                         overrun
);
  localparam int IW = $clog2(N_NEURONS);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [W-1:0]         v_q [N_NEURONS];
  logic [N_NEURONS-1:0] shadow_q, shadow_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic [W-1:0]         v_mon_q, v_mon_d;
  logic                 overrun_q, overrun_d;

  logic [W-1:0]         v_cur, leak_amt, v_sat, wr_val;
  logic [W:0]           v_sum;
  logic                 fire, upd, last;
  logic [N_NEURONS-1:0] spike_bit;

  assign v_cur    = v_q[idx_q];
  assign leak_amt = (leak_shift == 3'd0) ? '0 : (v_cur >> leak_shift);
  // v - leak never underflows, so only the upper end needs saturation.
  assign v_sum    = {1'b0, v_cur} - {1'b0, leak_amt} + {1'b0, cur_in};
  assign v_sat    = v_sum[W] ? '1 : v_sum[W-1:0];

`ifdef LIF_SCHED_REFRACTORY_EN
  logic [1:0] ref_q [N_NEURONS];
  logic       in_ref;

  assign in_ref = (ref_q[idx_q] != 2'd0);
  assign fire   = !in_ref && (threshold != '0) && (v_sat >= threshold);
  assign wr_val = (fire || in_ref) ? '0 : v_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) ref_q[n] <= 2'd0;
    end else if (upd) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (idx_q == IW'(n)) begin
          if (in_ref)    ref_q[n] <= ref_q[n] - 2'd1;
          else if (fire) ref_q[n] <= 2'd2;
        end
      end
    end
  end
`else
  assign fire   = (threshold != '0) && (v_sat >= threshold);
  assign wr_val = fire ? '0 : v_sat;
`endif

  assign upd       = ena && (state_q == SWEEP);
  assign last      = (idx_q == IW'(N_NEURONS - 1));
  assign spike_bit = fire ? (N_NEURONS'(1) << idx_q) : '0;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    spikes_d  = spikes_q;
    v_mon_d   = v_mon_q;
    overrun_d = overrun_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_d  = SWEEP;
            idx_d    = '0;
            shadow_d = '0;
          end
        end
        SWEEP: begin
          shadow_d = shadow_q | spike_bit;
          v_mon_d  = wr_val;
          if (tick) overrun_d = 1'b1;
          if (last) begin
            state_d  = DONE;
            idx_d    = '0;
            // Publish including the final neuron's bit computed this cycle.
            spikes_d = shadow_q | spike_bit;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          if (tick) overrun_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      spikes_q  <= '0;
      v_mon_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      spikes_q  <= spikes_d;
      v_mon_q   <= v_mon_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) v_q[n] <= '0;
    end else if (upd) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (idx_q == IW'(n)) v_q[n] <= wr_val;
      end
    end
  end

  assign cur_idx = (state_q == SWEEP) ? idx_q : '0;
  assign busy    = (state_q == SWEEP);
  assign done    = (state_q == DONE);
  assign spikes  = spikes_q;
  assign v_mon   = v_mon_q;
  assign overrun = overrun_q;

endmodule
